// File: rtl/pipe_pkg.sv
// Shared types and default widths for the parametrised pipeline stage register.
package pipe_pkg;

    // Occupancy of a skid-mode stage: nothing held, output entry only, or
    // output entry plus skid entry.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_e;

    localparam int DEF_CTRL_W = 16;
    localparam int DEF_DATA_W = 64;
    localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid flag, control field and data field.
// Clear drops the entry and zeroes control so a bubble never carries live
// control bits; data is left as it was. Clear wins over load.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] ld_ctrl,
    input  logic [DATA_W-1:0] ld_data,
    output logic              vld,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    // Entry register: reset empties it, clear drops it, load captures a beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld  <= 1'b0;
            ctrl <= '0;
            data <= '0;
        end else if (clear) begin
            vld  <= 1'b0;
            ctrl <= '0;
        end else if (load) begin
            vld  <= 1'b1;
            ctrl <= ld_ctrl;
            data <= ld_data;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, flush for
// bubble insertion, optional two-entry skid buffer (registered in_ready) and a
// saturating stall counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int SKID   = 0,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    // Output entry (stage p1)
    logic              vld_p1;
    logic [CTRL_W-1:0] ctrl_p1;
    logic [DATA_W-1:0] data_p1;

    logic              accept;
    logic              rel;
    logic              out_load;
    logic              out_clear;
    logic [CTRL_W-1:0] ld_ctrl;
    logic [DATA_W-1:0] ld_data;
    logic [CNT_W-1:0]  stall_q;

    assign accept = in_valid & in_ready;
    assign rel    = vld_p1 & out_ready;

    pipe_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_out (
        .clk     (clk),
        .rst     (rst),
        .load    (out_load),
        .clear   (out_clear),
        .ld_ctrl (ld_ctrl),
        .ld_data (ld_data),
        .vld     (vld_p1),
        .ctrl    (ctrl_p1),
        .data    (data_p1)
    );

    generate
        if (SKID == 0) begin : g_single

            // Single entry: ready whenever the entry is free or leaving now.
            assign in_ready = ~vld_p1 | out_ready;

            // Load on accept, drop on release-without-refill; flush drops all.
            always_comb begin
                out_load  = accept & ~flush;
                out_clear = flush | (rel & ~accept);
                ld_ctrl   = in_ctrl;
                ld_data   = in_data;
            end

        end else begin : g_skid

            // Skid entry (stage p0): holds the beat accepted while the
            // output entry is stalled, so in_ready can come from a flop.
            logic              vld_p0;
            logic [CTRL_W-1:0] ctrl_p0;
            logic [DATA_W-1:0] data_p0;
            logic              skid_load;
            logic              skid_clear;
            stage_state_e      state_q;
            stage_state_e      state_nxt;
            logic              rdy_q;

            assign in_ready = rdy_q;

            pipe_slot #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W)
            ) u_skid (
                .clk     (clk),
                .rst     (rst),
                .load    (skid_load),
                .clear   (skid_clear),
                .ld_ctrl (in_ctrl),
                .ld_data (in_data),
                .vld     (vld_p0),
                .ctrl    (ctrl_p0),
                .data    (data_p0)
            );

            // Occupancy transitions and entry steering; flush empties both
            // entries and discards any beat accepted in the same cycle.
            always_comb begin
                state_nxt  = state_q;
                out_load   = 1'b0;
                out_clear  = 1'b0;
                skid_load  = 1'b0;
                skid_clear = 1'b0;
                ld_ctrl    = in_ctrl;
                ld_data    = in_data;
                if (flush) begin
                    state_nxt  = EMPTY;
                    out_clear  = 1'b1;
                    skid_clear = 1'b1;
                end else begin
                    case (state_q)
                        EMPTY: begin
                            if (accept) begin
                                out_load  = 1'b1;
                                state_nxt = ONE;
                            end
                        end
                        ONE: begin
                            if (accept && rel) begin
                                out_load = 1'b1;
                            end else if (accept) begin
                                skid_load = 1'b1;
                                state_nxt = TWO;
                            end else if (rel) begin
                                out_clear = 1'b1;
                                state_nxt = EMPTY;
                            end
                        end
                        TWO: begin
                            if (rel && vld_p0) begin
                                out_load   = 1'b1;
                                ld_ctrl    = ctrl_p0;
                                ld_data    = data_p0;
                                skid_clear = 1'b1;
                                state_nxt  = ONE;
                            end
                        end
                        default: begin
                            out_clear  = 1'b1;
                            skid_clear = 1'b1;
                            state_nxt  = EMPTY;
                        end
                    endcase
                end
            end

            // State and registered in_ready: ready unless both entries full.
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q <= EMPTY;
                    rdy_q   <= 1'b1;
                end else begin
                    state_q <= state_nxt;
                    rdy_q   <= (state_nxt != TWO);
                end
            end

        end
    endgenerate

    // Stall counter: cycles where a beat is offered but not taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (vld_p1 && !out_ready) begin
            stall_q <= sat_inc(stall_q);
        end
    end

    assign out_valid = vld_p1;
    assign out_ctrl  = ctrl_p1;
    assign out_data  = data_p1;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: u0 is a plain register (SKID=0), u1 a skid buffer
// with a 4-bit stall counter. Directed sequences check hand-computed values;
// a per-instance scoreboard checks the released stream and the bubble rule.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic [15:0] c;
        logic [63:0] d;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;

    logic        flush0, in_valid0, in_ready0, out_valid0, out_ready0;
    logic [15:0] in_ctrl0, out_ctrl0, stall_cnt0;
    logic [63:0] in_data0, out_data0;

    logic        flush1, in_valid1, in_ready1, out_valid1, out_ready1;
    logic [15:0] in_ctrl1, out_ctrl1;
    logic [63:0] in_data1, out_data1;
    logic [3:0]  stall_cnt1;

    beat_t q0[$];
    beat_t q1[$];
    int    errs   = 0;
    int    checks = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(16), .DATA_W(64), .SKID(0), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .flush(flush0),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_ctrl(in_ctrl0), .in_data(in_data0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_ctrl(out_ctrl0), .out_data(out_data0),
        .stall_cnt(stall_cnt0)
    );

    pipe_stage_reg #(.CTRL_W(16), .DATA_W(64), .SKID(1), .CNT_W(4)) u1 (
        .clk(clk), .rst(rst), .flush(flush1),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_ctrl(in_ctrl1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_ctrl(out_ctrl1), .out_data(out_data1),
        .stall_cnt(stall_cnt1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for u0: evaluated at negedge for the handshake at the next posedge.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            q0.delete();
        end else begin
            if (!out_valid0) chk("bubble0", 64'(out_ctrl0), 64'd0);
            if (out_valid0 && out_ready0) begin
                if (q0.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL sb0_extra: got beat ctrl=%0h expected none", out_ctrl0);
                end else begin
                    e = q0.pop_front();
                    chk("sb0_ctrl", 64'(out_ctrl0), 64'(e.c));
                    chk("sb0_data", out_data0, e.d);
                end
            end
            if (flush0) q0.delete();
            else if (in_valid0 && in_ready0) q0.push_back({in_ctrl0, in_data0});
        end
    end

    // Scoreboard for u1.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            q1.delete();
        end else begin
            if (!out_valid1) chk("bubble1", 64'(out_ctrl1), 64'd0);
            if (out_valid1 && out_ready1) begin
                if (q1.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL sb1_extra: got beat ctrl=%0h expected none", out_ctrl1);
                end else begin
                    e = q1.pop_front();
                    chk("sb1_ctrl", 64'(out_ctrl1), 64'(e.c));
                    chk("sb1_data", out_data1, e.d);
                end
            end
            if (flush1) q1.delete();
            else if (in_valid1 && in_ready1) q1.push_back({in_ctrl1, in_data1});
        end
    end

    initial begin
        rst = 1'b1;
        flush0 = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b0; in_ctrl0 = '0; in_data0 = '0;
        flush1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0; in_ctrl1 = '0; in_data1 = '0;
        cyc();
        cyc();
        rst = 1'b0;

        // Reset state of both instances
        @(negedge clk);
        chk("rst_vld0", 64'(out_valid0), 64'd0);
        chk("rst_ctrl0", 64'(out_ctrl0), 64'd0);
        chk("rst_data0", out_data0, 64'd0);
        chk("rst_cnt0", 64'(stall_cnt0), 64'd0);
        chk("rst_rdy0", 64'(in_ready0), 64'd1);
        chk("rst_vld1", 64'(out_valid1), 64'd0);
        chk("rst_data1", out_data1, 64'd0);
        chk("rst_rdy1", 64'(in_ready1), 64'd1);
        chk("rst_cnt1", 64'(stall_cnt1), 64'd0);
        cyc();

        // SKID=0 pass-through
        in_valid0 = 1'b1; in_ctrl0 = 16'h00A5; in_data0 = 64'h1234; out_ready0 = 1'b1;
        @(negedge clk);
        chk("pt_rdy", 64'(in_ready0), 64'd1);
        cyc();
        in_valid0 = 1'b0;
        @(negedge clk);
        chk("pt_vld", 64'(out_valid0), 64'd1);
        chk("pt_ctrl", 64'(out_ctrl0), 64'h00A5);
        chk("pt_data", out_data0, 64'h1234);
        cyc();

        // SKID=0 continuous stream of 8 beats, one per cycle
        for (int i = 0; i <= 8; i++) begin
            in_valid0 = (i < 8);
            in_ctrl0  = 16'(16'h0100 + i);
            in_data0  = 64'(64'hD000 + i);
            @(negedge clk);
            if (i > 0) begin
                chk("st_vld", 64'(out_valid0), 64'd1);
                chk("st_ctrl", 64'(out_ctrl0), 64'(16'h0100 + i - 1));
                chk("st_data", out_data0, 64'(64'hD000 + i - 1));
            end
            chk("st_rdy", 64'(in_ready0), 64'd1);
            cyc();
        end

        // SKID=0 backpressure: combinational in_ready drops while held
        in_valid0 = 1'b1; in_ctrl0 = 16'h0B01; in_data0 = 64'hB1; out_ready0 = 1'b0;
        @(negedge clk);
        chk("bp0_rdy_a", 64'(in_ready0), 64'd1);
        cyc();
        in_ctrl0 = 16'h0B02; in_data0 = 64'hB2;
        @(negedge clk);
        chk("bp0_rdy_b", 64'(in_ready0), 64'd0);
        chk("bp0_ctrl_b", 64'(out_ctrl0), 64'h0B01);
        chk("bp0_cnt_b", 64'(stall_cnt0), 64'd0);
        cyc();
        out_ready0 = 1'b1;
        @(negedge clk);
        chk("bp0_rdy_c", 64'(in_ready0), 64'd1);
        chk("bp0_cnt_c", 64'(stall_cnt0), 64'd1);
        chk("bp0_ctrl_c", 64'(out_ctrl0), 64'h0B01);
        cyc();
        in_valid0 = 1'b0;
        @(negedge clk);
        chk("bp0_ctrl_d", 64'(out_ctrl0), 64'h0B02);
        cyc();
        @(negedge clk);
        chk("bp0_vld_e", 64'(out_valid0), 64'd0);
        chk("bp0_cnt_e", 64'(stall_cnt0), 64'd1);
        cyc();

        // SKID=1 backpressure: A held, B in skid, C refused
        out_ready1 = 1'b0;
        in_valid1 = 1'b1; in_ctrl1 = 16'h0A01; in_data1 = 64'hA1;
        @(negedge clk);
        chk("bp1_rdy_a", 64'(in_ready1), 64'd1);
        chk("bp1_vld_a", 64'(out_valid1), 64'd0);
        cyc();
        in_ctrl1 = 16'h0A02; in_data1 = 64'hA2;
        @(negedge clk);
        chk("bp1_rdy_b", 64'(in_ready1), 64'd1);
        chk("bp1_ctrl_b", 64'(out_ctrl1), 64'h0A01);
        chk("bp1_cnt_b", 64'(stall_cnt1), 64'd0);
        cyc();
        in_ctrl1 = 16'h0A03; in_data1 = 64'hA3;
        @(negedge clk);
        chk("bp1_rdy_c", 64'(in_ready1), 64'd0);
        chk("bp1_ctrl_c", 64'(out_ctrl1), 64'h0A01);
        chk("bp1_cnt_c", 64'(stall_cnt1), 64'd1);
        cyc();
        @(negedge clk);
        chk("bp1_rdy_d", 64'(in_ready1), 64'd0);
        chk("bp1_data_d", out_data1, 64'hA1);
        chk("bp1_cnt_d", 64'(stall_cnt1), 64'd2);
        cyc();
        out_ready1 = 1'b1;
        @(negedge clk);
        chk("bp1_cnt_e", 64'(stall_cnt1), 64'd3);
        chk("bp1_rdy_e", 64'(in_ready1), 64'd0);
        chk("bp1_ctrl_e", 64'(out_ctrl1), 64'h0A01);
        cyc();
        @(negedge clk);
        chk("bp1_rdy_f", 64'(in_ready1), 64'd1);
        chk("bp1_ctrl_f", 64'(out_ctrl1), 64'h0A02);
        chk("bp1_data_f", out_data1, 64'hA2);
        cyc();
        in_valid1 = 1'b0;
        @(negedge clk);
        chk("bp1_ctrl_g", 64'(out_ctrl1), 64'h0A03);
        chk("bp1_data_g", out_data1, 64'hA3);
        chk("bp1_cnt_g", 64'(stall_cnt1), 64'd3);
        cyc();
        @(negedge clk);
        chk("bp1_vld_h", 64'(out_valid1), 64'd0);
        chk("bp1_ctrl_h", 64'(out_ctrl1), 64'd0);
        cyc();

        // SKID=1 flush in state TWO together with in_valid and a release
        out_ready1 = 1'b0;
        in_valid1 = 1'b1; in_ctrl1 = 16'h0D01; in_data1 = 64'hD1;
        cyc();
        in_ctrl1 = 16'h0D02; in_data1 = 64'hD2;
        @(negedge clk);
        chk("fl_ctrl_e", 64'(out_ctrl1), 64'h0D01);
        cyc();
        in_ctrl1 = 16'h0D03; in_data1 = 64'hD3; flush1 = 1'b1; out_ready1 = 1'b1;
        @(negedge clk);
        chk("fl_rdy_two", 64'(in_ready1), 64'd0);
        chk("fl_cnt_pre", 64'(stall_cnt1), 64'd4);
        cyc();
        flush1 = 1'b0; in_valid1 = 1'b0;
        @(negedge clk);
        chk("fl_vld", 64'(out_valid1), 64'd0);
        chk("fl_ctrl", 64'(out_ctrl1), 64'd0);
        chk("fl_rdy", 64'(in_ready1), 64'd1);
        chk("fl_cnt", 64'(stall_cnt1), 64'd4);
        chk("fl_data_hold", out_data1, 64'hD1);
        cyc();
        @(negedge clk);
        chk("fl_vld2", 64'(out_valid1), 64'd0);
        cyc();

        // Saturation of the 4-bit counter, then reset while in state TWO
        out_ready1 = 1'b0;
        in_valid1 = 1'b1; in_ctrl1 = 16'h0E01; in_data1 = 64'hE1;
        cyc();
        in_ctrl1 = 16'h0E02; in_data1 = 64'hE2;
        cyc();
        in_valid1 = 1'b0;
        for (int i = 0; i < 20; i++) cyc();
        @(negedge clk);
        chk("sat_cnt", 64'(stall_cnt1), 64'd15);
        chk("sat_ctrl", 64'(out_ctrl1), 64'h0E01);
        chk("sat_rdy", 64'(in_ready1), 64'd0);
        cyc();
        @(negedge clk);
        chk("sat_hold", 64'(stall_cnt1), 64'd15);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("mr_vld", 64'(out_valid1), 64'd0);
        chk("mr_ctrl", 64'(out_ctrl1), 64'd0);
        chk("mr_data", out_data1, 64'd0);
        chk("mr_cnt", 64'(stall_cnt1), 64'd0);
        chk("mr_rdy", 64'(in_ready1), 64'd1);
        chk("mr_cnt0", 64'(stall_cnt0), 64'd0);
        out_ready1 = 1'b1;
        cyc();
        cyc();
        @(negedge clk);
        chk("mr_empty", 64'(out_valid1), 64'd0);
        cyc();

        // Random traffic with flushes on both instances
        for (int n = 0; n < 3000; n++) begin
            in_valid0  = 1'($urandom_range(0, 1));
            out_ready0 = 1'($urandom_range(0, 1));
            flush0     = ($urandom_range(0, 19) == 0);
            in_ctrl0   = 16'($urandom);
            in_data0   = {$urandom, $urandom};
            in_valid1  = 1'($urandom_range(0, 1));
            out_ready1 = 1'($urandom_range(0, 1));
            flush1     = ($urandom_range(0, 19) == 0);
            in_ctrl1   = 16'($urandom);
            in_data1   = {$urandom, $urandom};
            cyc();
        end
        in_valid0 = 1'b0; flush0 = 1'b0; out_ready0 = 1'b1;
        in_valid1 = 1'b0; flush1 = 1'b0; out_ready1 = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        @(negedge clk);
        chk("drain_q0", 64'(q0.size()), 64'd0);
        chk("drain_q1", 64'(q1.size()), 64'd0);
        chk("drain_vld0", 64'(out_valid0), 64'd0);
        chk("drain_vld1", 64'(out_valid1), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
